// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the fetch PC, keeps one word request outstanding to imem, and buffers
// {pc, instr} pairs in a DEPTH-entry FIFO feeding decode; a redirect flushes the buffer and drops any in-flight word.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        Stall,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] PC
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   fetch_pc, req_pc, target_aligned;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          push, pop;
  logic [CW:0]   occ_nxt;

  assign target_aligned = PCTarget & 32'hFFFF_FFFC;
  assign imem_addr      = fetch_pc;
  assign InstrValid     = (count != '0);
  assign Instr          = InstrValid ? instr_mem[rd_ptr] : NOP;
  assign PC             = InstrValid ? pc_mem[rd_ptr] : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (imem_req) state_nxt = WAIT;
      WAIT: begin
        if (PCSrc)            state_nxt = imem_rvalid ? IDLE : DROP;
        else if (imem_rvalid) state_nxt = imem_req ? WAIT : IDLE;
      end
      DROP: if (imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requests are gated on next-cycle occupancy so a returning word always has a slot.
  // DROP never requests: the target fetch goes out the cycle after the dropped word returns.
  always_comb begin
    pop      = InstrValid & ~Stall;
    push     = imem_rvalid & (state == WAIT) & ~PCSrc;
    occ_nxt  = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    imem_req = ~reset & ~PCSrc
             & ((state == IDLE) | ((state == WAIT) & imem_rvalid))
             & (occ_nxt < (CW+1)'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else if (PCSrc) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= target_aligned;
    end else begin
      if (imem_req) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= occ_nxt[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= req_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand sequences and random traffic against a queue model.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = 32'h0;
  logic        Stall = 1'b0;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] PC;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .PCSrc(PCSrc),
    .PCTarget(PCTarget), .Stall(Stall), .InstrValid(InstrValid),
    .Instr(Instr), .PC(PC)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct {
    bit stall; bit pcsrc; logic [31:0] tgt;
    bit req; logic [31:0] addr; bit valid; logic [31:0] pc;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: buffer contents, outstanding/discard flags, fetch address.
  ent_t        mq[$];
  bit          m_out, m_disc;
  logic [31:0] m_fpc, m_rpc;

  // Memory model: single outstanding request with a per-request latency.
  bit          mem_busy;
  int          mem_due, cyc, lat_min, lat_max;
  logic [31:0] mem_addr;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  vec_t tbl[15];

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out = 0; m_disc = 0;
    m_fpc = RESET_PC; m_rpc = RESET_PC;
    mem_busy = 0; mem_due = 0; cyc = 0; mem_addr = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_rvalid = 1'b0; Stall = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst imem_req", imem_req, 0);
    chk("rst InstrValid", InstrValid, 0);
    chk("rst Instr", Instr, NOP);
    chk("rst PC", PC, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic step(input bit st, input bit ps, input logic [31:0] tg);
    bit          rv, e_valid, e_pop, e_push, e_req;
    int          occ;
    logic [31:0] rd;
    ent_t        e;
    @(negedge clk);
    rv = mem_busy && (cyc == mem_due);
    rd = rv ? word(mem_addr) : $urandom;
    imem_rvalid = rv; imem_rdata = rd;
    Stall = st; PCSrc = ps; PCTarget = tg;
    #1;
    e_valid = (mq.size() > 0);
    e_pop   = e_valid & ~st;
    e_push  = rv & m_out & ~m_disc & ~ps;
    occ     = mq.size() + int'(e_push) - int'(e_pop);
    e_req   = ~ps & (~m_out | (~m_disc & rv)) & (occ < DEPTH);
    s_req = imem_req; s_addr = imem_addr; s_valid = InstrValid; s_pc = PC; s_instr = Instr;
    chk("imem_req", s_req, e_req);
    if (e_req) chk("imem_addr", s_addr, m_fpc);
    chk("InstrValid", s_valid, e_valid);
    if (e_valid) begin
      chk("PC", s_pc, mq[0].pc);
      chk("Instr", s_instr, mq[0].instr);
    end else begin
      chk("PC empty", s_pc, 0);
      chk("Instr empty", s_instr, NOP);
    end
    if (rv) mem_busy = 0;
    if (s_req) begin
      mem_busy = 1; mem_addr = s_addr;
      mem_due = cyc + int'($urandom_range(lat_max, lat_min));
    end
    if (ps) begin
      mq.delete();
      m_fpc = tg & 32'hFFFF_FFFC;
      if (m_out && !rv) m_disc = 1;
      else begin m_out = 0; m_disc = 0; end
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (e_push) begin e.pc = m_rpc; e.instr = rd; mq.push_back(e); end
      if (rv) begin m_out = 0; m_disc = 0; end
      if (e_req) begin m_out = 1; m_rpc = m_fpc; m_fpc = m_fpc + 32'd4; end
    end
    cyc++;
  endtask

  task automatic setv(input int i, input bit st, input bit ps, input logic [31:0] tg,
                      input bit rq, input logic [31:0] ad, input bit vl, input logic [31:0] pc);
    tbl[i].stall = st; tbl[i].pcsrc = ps; tbl[i].tgt = tg;
    tbl[i].req = rq; tbl[i].addr = ad; tbl[i].valid = vl; tbl[i].pc = pc;
  endtask

  initial begin
    bit found;

    // 1-cycle memory: startup stream, stall from cycle 3, release, then redirect coincident with rvalid and pop.
    setv( 0, 0, 0, 0,          1, 32'h000, 0, 32'h000);
    setv( 1, 0, 0, 0,          1, 32'h004, 0, 32'h000);
    setv( 2, 0, 0, 0,          1, 32'h008, 1, 32'h000);
    setv( 3, 1, 0, 0,          0, 32'h000, 1, 32'h004);
    setv( 4, 1, 0, 0,          0, 32'h000, 1, 32'h004);
    setv( 5, 1, 0, 0,          0, 32'h000, 1, 32'h004);
    setv( 6, 0, 0, 0,          1, 32'h00C, 1, 32'h004);
    setv( 7, 0, 0, 0,          1, 32'h010, 1, 32'h008);
    setv( 8, 0, 0, 0,          1, 32'h014, 1, 32'h00C);
    setv( 9, 0, 0, 0,          1, 32'h018, 1, 32'h010);
    setv(10, 0, 1, 32'h200,    0, 32'h000, 1, 32'h014);
    setv(11, 0, 0, 0,          1, 32'h200, 0, 32'h000);
    setv(12, 0, 0, 0,          1, 32'h204, 0, 32'h000);
    setv(13, 0, 0, 0,          1, 32'h208, 1, 32'h200);
    setv(14, 0, 0, 0,          1, 32'h20C, 1, 32'h204);

    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].stall, tbl[i].pcsrc, tbl[i].tgt);
      chk($sformatf("tbl%0d req", i), s_req, tbl[i].req);
      if (tbl[i].req) chk($sformatf("tbl%0d addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d valid", i), s_valid, tbl[i].valid);
      chk($sformatf("tbl%0d pc", i), s_pc, tbl[i].pc);
      chk($sformatf("tbl%0d instr", i), s_instr, tbl[i].valid ? word(tbl[i].pc) : NOP);
    end

    // 3-cycle memory, redirect one cycle after the first request.
    lat_min = 3; lat_max = 3;
    do_reset();
    step(0, 0, 0);
    step(0, 1, 32'h0000_0103);
    chk("redir valid", s_valid, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0);
      if (s_req) begin found = 1; chk("redir addr", s_addr, 32'h100); end
    end
    if (!found) chk("redir req timeout", 0, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0);
      if (s_valid) begin found = 1; chk("redir first pc", s_pc, 32'h100); end
    end
    if (!found) chk("redir valid timeout", 0, 1);

    // Fetch PC wrap past 0xFFFF_FFFC.
    lat_min = 1; lat_max = 1;
    step(0, 1, 32'hFFFF_FFFF);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0);
      if (s_req) begin found = 1; chk("wrap addr0", s_addr, 32'hFFFF_FFFC); end
    end
    if (!found) chk("wrap req timeout", 0, 1);
    step(0, 0, 0);
    chk("wrap req1", s_req, 1);
    chk("wrap addr1", s_addr, 32'h0);

    // Asynchronous reset with an entry buffered and a request outstanding.
    lat_min = 4; lat_max = 4;
    do_reset();
    repeat (6) step(1, 0, 0);
    chk("pre-rst valid", s_valid, 1);
    @(negedge clk);
    imem_rvalid = 1'b0; PCSrc = 1'b0; Stall = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async InstrValid", InstrValid, 0);
    chk("async Instr", Instr, NOP);
    chk("async PC", PC, 0);
    chk("async imem_req", imem_req, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    step(0, 0, 0);
    chk("post-rst req", s_req, 1);
    chk("post-rst addr", s_addr, RESET_PC);

    // Random traffic: single-cycle memory first, then variable latency.
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1000) begin lat_min = 1; lat_max = 4; end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                       : 32'($urandom_range(0, 1023)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
